// File: rtl/sound_arbiter_if.sv
// sound_arbiter_if: request/enable inputs and sound-control outputs of the arbiter
interface sound_arbiter_if;
  logic [3:0] req;
  logic       enable;
  logic       mute;
  logic [1:0] code_sound;
  logic [3:0] grant;
  logic       busy;
  logic [3:0] pending;
  modport master(output req, enable, input mute, code_sound, grant, busy, pending);
  modport slave(input req, enable, output mute, code_sound, grant, busy, pending);
endinterface

// File: rtl/sound_arbiter.sv
// sound_arbiter: round-robin sharing of one sound voice with timed play and silent gap
module sound_arbiter #(
  parameter int TICK_DIV = 12000,
  parameter int PLAY_MS  = 100,
  parameter int GAP_MS   = 20
) (
  input logic            clk,
  input logic            clr,
  sound_arbiter_if.slave bus
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int TMAX = PLAY_MS > GAP_MS ? PLAY_MS : GAP_MS;
  localparam int TW = $clog2(TMAX + 1);
  localparam logic [1:0] IDLE = 2'd0, PLAY = 2'd1, GAP = 2'd2;
  localparam logic [1:0] AFTER_PLAY = GAP_MS == 0 ? IDLE : GAP;
  logic [1:0] state_q, state_d, last_q, last_d, code_q, code_d, win;
  logic [PW-1:0] pre_q, pre_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [3:0] pend_q, pend_d, grant_q, grant_d, cand, gmask;
  logic go, wrap, clear;
  always_comb begin
    cand = pend_q | bus.req;
    win = last_q;
    for (int k = 4; k >= 1; k--)
      if (cand[2'(last_q + 2'(k))]) win = 2'(last_q + 2'(k));
    go = state_q == IDLE && bus.enable && |cand;
    gmask = go ? 4'b0001 << win : 4'b0000;
    wrap = pre_q == PW'(TICK_DIV - 1);
    state_d = go ? PLAY
      : state_q == PLAY && (!bus.enable || (wrap && tick_q == TW'(PLAY_MS - 1))) ? AFTER_PLAY
      : state_q == GAP && wrap && tick_q == TW'(GAP_MS - 1) ? IDLE
      : state_q;
    clear = state_d != state_q || state_q == IDLE;
    pre_d = clear || wrap ? '0 : pre_q + 1'b1;
    tick_d = clear ? '0 : tick_q + TW'(wrap);
    last_d = go ? win : last_q;
    code_d = go ? win : code_q;
    grant_d = gmask;
    // a granted bit survives only if an earlier request was still queued alongside the new one
    pend_d = (pend_q & bus.req) | (cand & ~gmask);
  end
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      last_q  <= 2'd3;
      code_q  <= '0;
      pre_q   <= '0;
      tick_q  <= '0;
      pend_q  <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      code_q  <= code_d;
      pre_q   <= pre_d;
      tick_q  <= tick_d;
      pend_q  <= pend_d;
      grant_q <= grant_d;
    end
  end
  assign bus.mute       = state_q != PLAY;
  assign bus.busy       = state_q != IDLE;
  assign bus.code_sound = code_q;
  assign bus.grant      = grant_q;
  assign bus.pending    = pend_q;
endmodule

// File: tb/tb_sound_arbiter.sv
// tb_sound_arbiter: table vectors, directed corner sequences and random stimulus vs a countdown model
module tb_sound_arbiter;
  localparam int T = 4, P = 3;
  logic clk = 0, clr = 1, en = 1;
  logic [3:0] rq = 0;
  int errors = 0, checks = 0;
  int bl[2], pl[2], lst[2];
  logic [3:0] pd[2], gr[2];
  logic [1:0] cd[2];
  sound_arbiter_if b0();
  sound_arbiter_if b1();
  assign b0.req = rq;
  assign b1.req = rq;
  assign b0.enable = en;
  assign b1.enable = en;
  sound_arbiter #(.TICK_DIV(4), .PLAY_MS(3), .GAP_MS(2)) u0 (.clk(clk), .clr(clr), .bus(b0.slave));
  sound_arbiter #(.TICK_DIV(4), .PLAY_MS(3), .GAP_MS(0)) u1 (.clk(clk), .clr(clr), .bus(b1.slave));
  always #5 clk = ~clk;

  // outputs packed as {mute, code[1:0], grant[3:0], busy, pending[3:0]}
  function automatic logic [11:0] outs(input int d);
    return d == 0 ? {b0.mute, b0.code_sound, b0.grant, b0.busy, b0.pending}
                  : {b1.mute, b1.code_sound, b1.grant, b1.busy, b1.pending};
  endfunction

  function automatic logic [11:0] mexp(input int d);
    return {pl[d] == 0, cd[d], gr[d], bl[d] > 0, pd[d]};
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, x);
    end
  endtask

  // time-remaining model: a grant books PLAY*T cycles of sound inside (PLAY+GAP)*T busy cycles
  task automatic model(input int d, input logic c, input logic [3:0] r, input logic e);
    int w, g, cnt, i;
    g = d == 0 ? 2 : 0;
    w = -1;
    if (c) begin
      bl[d] = 0; pl[d] = 0; pd[d] = 0; lst[d] = 3; cd[d] = 0; gr[d] = 0;
      return;
    end
    gr[d] = 0;
    if (bl[d] == 0) begin
      if (e)
        for (int k = 1; k <= 4; k++) begin
          i = (lst[d] + k) % 4;
          if (w < 0 && (pd[d][i] || r[i])) w = i;
        end
      if (w >= 0) begin
        gr[d] = 4'(1 << w);
        cd[d] = 2'(w);
        lst[d] = w;
        pl[d] = P * T;
        bl[d] = (P + g) * T;
      end
    end else if (pl[d] > 0 && !e) begin
      pl[d] = 0;
      bl[d] = g * T;
    end else begin
      bl[d]--;
      if (pl[d] > 0) pl[d]--;
    end
    for (int j = 0; j < 4; j++) begin
      cnt = int'(pd[d][j]) + int'(r[j]) - int'(gr[d][j]);
      pd[d][j] = cnt > 0;
    end
  endtask

  task automatic step;
    model(0, clr, rq, en);
    model(1, clr, rq, en);
    @(posedge clk);
    #1;
    chk("model0", outs(0), mexp(0));
    chk("model1", outs(1), mexp(1));
  endtask

  task automatic wait_grant(input int d, input int mx, output logic [3:0] g, output int n);
    logic [11:0] o;
    g = 0;
    n = 0;
    while (n < mx) begin
      step;
      n++;
      o = outs(d);
      if (o[8:5] != 0) begin
        g = o[8:5];
        break;
      end
    end
  endtask

  task automatic do_reset;
    clr = 1;
    rq = 0;
    step;
    clr = 0;
  endtask

  typedef struct {
    logic c;
    logic [3:0] r;
    logic e;
    logic [11:0] x;
  } vec_t;
  vec_t tbl[5];

  initial begin
    logic [11:0] o;
    logic [3:0] g, gsum;
    int n, lowc, busyc, gapc;
    tbl[0] = '{1'b1, 4'b1111, 1'b1, 12'b1_00_0000_0_0000};
    tbl[1] = '{1'b1, 4'b1111, 1'b1, 12'b1_00_0000_0_0000};
    tbl[2] = '{1'b0, 4'b0000, 1'b1, 12'b1_00_0000_0_0000};
    tbl[3] = '{1'b0, 4'b0100, 1'b1, 12'b0_10_0100_1_0000};
    tbl[4] = '{1'b0, 4'b0000, 1'b1, 12'b0_10_0000_1_0000};
    for (int v = 0; v < 5; v++) begin
      clr = tbl[v].c;
      rq = tbl[v].r;
      en = tbl[v].e;
      step;
      chk($sformatf("vec%0d", v), outs(0), tbl[v].x);
    end
    lowc = 2;
    busyc = 2;
    for (int k = 0; k < 100; k++) begin
      step;
      o = outs(0);
      if (!o[4]) break;
      busyc++;
      if (!o[11]) lowc++;
    end
    chk("play_len", lowc, 12);
    chk("busy_len", busyc, 20);

    do_reset;
    rq = 4'b1011;
    step;
    rq = 0;
    o = outs(0);
    chk("rr_g0", o[8:5], 4'b0001);
    chk("rr_p0", o[3:0], 4'b1010);
    wait_grant(0, 100, g, n);
    o = outs(0);
    chk("rr_g1", g, 4'b0010);
    chk("rr_gap1", n, 21);
    chk("rr_p1", o[3:0], 4'b1000);
    wait_grant(0, 100, g, n);
    o = outs(0);
    chk("rr_g3", g, 4'b1000);
    chk("rr_gap3", n, 21);
    chk("rr_p3", o[3:0], 4'b0000);
    wait_grant(0, 60, g, n);
    chk("rr_none", g, 4'b0000);

    do_reset;
    rq = 4'b0011;
    step;
    o = outs(0);
    chk("sw_g0", o[8:5], 4'b0001);
    chk("sw_p0", o[3:0], 4'b0010);
    wait_grant(0, 100, g, n);
    chk("sw_g1", g, 4'b0010);
    chk("sw_gap", n, 21);
    wait_grant(0, 100, g, n);
    o = outs(0);
    chk("sw_g0b", g, 4'b0001);
    chk("sw_p0b", o[0], 1'b1);
    wait_grant(0, 100, g, n);
    chk("sw_g1b", g, 4'b0010);

    do_reset;
    rq = 4'b0010;
    step;
    rq = 0;
    o = outs(0);
    chk("tr_g1", o[8:5], 4'b0010);
    repeat (4) step;
    en = 0;
    rq = 4'b1000;
    step;
    rq = 0;
    o = outs(0);
    chk("tr_mute", o[11], 1'b1);
    chk("tr_pend", o[3:0], 4'b1000);
    gapc = 1;
    gsum = 0;
    for (int k = 0; k < 50; k++) begin
      step;
      o = outs(0);
      gsum |= o[8:5];
      if (!o[4]) break;
      gapc++;
    end
    chk("tr_gap", gapc, 8);
    repeat (10) begin
      step;
      o = outs(0);
      gsum |= o[8:5];
    end
    chk("tr_nogrant", gsum, 4'b0000);
    chk("tr_pend2", o[3:0], 4'b1000);
    en = 1;
    step;
    o = outs(0);
    chk("tr_g3", o[8:5], 4'b1000);

    do_reset;
    rq = 4'b0001;
    step;
    rq = 4'b0100;
    step;
    rq = 0;
    repeat (2) step;
    clr = 1;
    rq = 4'b1111;
    step;
    chk("mid_clr0", outs(0), 12'b1_00_0000_0_0000);
    chk("mid_clr1", outs(1), 12'b1_00_0000_0_0000);
    clr = 0;
    rq = 0;
    step;
    chk("post_clr", outs(0), 12'b1_00_0000_0_0000);

    rq = 4'b0011;
    step;
    o = outs(1);
    chk("ng_g0", o[8:5], 4'b0001);
    wait_grant(1, 100, g, n);
    chk("ng_g1", g, 4'b0010);
    chk("ng_gap1", n, 13);
    wait_grant(1, 100, g, n);
    chk("ng_g0b", g, 4'b0001);
    chk("ng_gap2", n, 13);

    do_reset;
    for (int k = 0; k < 3000; k++) begin
      clr = $urandom % 300 == 0;
      rq = $urandom % 6 == 0 ? 4'($urandom) : 4'b0000;
      if ($urandom % 80 == 0) en = !en;
      step;
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
